// File: rtl/rxhs_pkg.sv
// Shared definitions for the RX handshake block: handshake FSM encoding,
// default sizing and the pointer-width helper used by the FIFO and the top.
package rxhs_pkg;

  // Handshake FSM states; ST_ERR is an unreachable recovery state.
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int unsigned RXHS_WIDTH = 55;
  localparam int unsigned RXHS_DEPTH = 4;

  // Pointer width for a FIFO of the given depth; the count is one bit wider.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rxhs_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data_o while
// the FIFO is non-empty (zero when empty). Owns the storage and pointers.
// Writes into a full FIFO and reads from an empty FIFO are ignored.
module rxhs_fifo
  import rxhs_pkg::*;
#(
  parameter int unsigned WIDTH = RXHS_WIDTH,
  parameter int unsigned DEPTH = RXHS_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [WIDTH-1:0]        wr_data_i,
  input  logic                    rd_en_i,
  output logic [WIDTH-1:0]        rd_data_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [ptr_w(DEPTH):0]   count_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_wr   = wr_en_i && !full_o;
  assign do_rd   = rd_en_i && !empty_o;

  // Next pointer and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/rx_handshake.sv
// Router-core side of the RX interface. Captures packets from the RX unit
// over a four-phase level handshake (RX_Data_Valid / RX_Data_Ack) into a
// show-ahead FIFO and presents them to the core as valid/data with a
// one-cycle take pulse.
//
// Optional build macro RXHS_PARITY_CHECK_EN: RX_Data[WIDTH-1] carries even
// parity over the rest of the packet; bad packets are acknowledged but
// dropped, and parity_err pulses for one cycle.
//
// Handshake semantics: the RX unit raises RX_Data_Valid with stable data and
// holds both until RX_Data_Ack is high; Ack then stays high until Valid falls.
// A packet is written only at an IDLE edge with Valid high and the FIFO not
// full (occupancy before any same-cycle take). On the core side, rc_data is
// valid whenever rc_data_valid is high; a take pulse while empty is ignored.
module rx_handshake
  import rxhs_pkg::*;
#(
  parameter int unsigned WIDTH = RXHS_WIDTH,
  parameter int unsigned DEPTH = RXHS_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX_Data_Valid,
  input  logic [WIDTH-1:0]       RX_Data,
  output logic                   RX_Data_Ack,
  output logic                   rc_data_valid,
  output logic [WIDTH-1:0]       rc_data,
  input  logic                   rc_data_taken,
  output logic [ptr_w(DEPTH):0]  fifo_count,
  output logic                   parity_err,
  output state_t                 fsm_state_o
);

  state_t state_q, state_d;
  logic   capture;
  logic   par_ok;
  logic   fifo_wr;
  logic   fifo_empty;
  logic   fifo_full;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RST;
    else     state_q <= state_d;
  end

  // Next-state logic; capture marks the single write edge of a handshake.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_RST:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (RX_Data_Valid && !fifo_full) begin
          capture = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  if (!RX_Data_Valid) state_d = ST_IDLE;
      ST_ERR:  state_d = ST_RST;
    endcase
  end

  // Ack is a pure decode of the registered state.
  assign RX_Data_Ack = (state_q == ST_ACK);
  assign fsm_state_o = state_q;

`ifdef RXHS_PARITY_CHECK_EN
  logic parity_err_q;

  // Even parity across the whole packet means the XOR of all bits is zero.
  assign par_ok = ~(^RX_Data);

  // One-cycle error pulse for a dropped packet, in the cycle after capture.
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= capture && !par_ok;
  end

  assign parity_err = parity_err_q;
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign fifo_wr = capture && par_ok;

  rxhs_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (RX_Data),
    .rd_en_i   (rc_data_taken),
    .rd_data_o (rc_data),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign rc_data_valid = !fifo_empty;

endmodule

// File: tb/tb_rx_handshake.sv
// Self-checking bench for rx_handshake: reset behaviour, single packet,
// fill/back-pressure, streaming wrap-around, edge inputs and (when built
// with RXHS_PARITY_CHECK_EN) the parity drop path.
module tb_rx_handshake;

  localparam int unsigned W = 55;
  localparam int unsigned D = 4;

  logic          clk;
  logic          rst;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic          rx_ack;
  logic          rc_valid;
  logic [W-1:0]  rc_data;
  logic          rc_taken;
  logic [2:0]    fifo_count;
  logic          parity_err;
  logic [1:0]    fsm_state;

  logic [W-1:0]  exp_q[$];
  int            n_checks;
  int            n_err;

  rx_handshake #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RX_Data_Valid (rx_valid),
    .RX_Data       (rx_data),
    .RX_Data_Ack   (rx_ack),
    .rc_data_valid (rc_valid),
    .rc_data       (rc_data),
    .rc_data_taken (rc_taken),
    .fifo_count    (fifo_count),
    .parity_err    (parity_err),
    .fsm_state_o   (fsm_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; drive and sample here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packet with a correct even-parity top bit over the payload.
  function automatic logic [W-1:0] pkt(input int unsigned v);
    logic [W-2:0] p;
    p = (W-1)'(v);
    return {^p, p};
  endfunction

  // Driver: full four-phase handshake for one packet, bounded wait on Ack.
  task automatic send_pkt(input logic [W-1:0] d, input string tag);
    int n;
    rx_data  = d;
    rx_valid = 1'b1;
    exp_q.push_back(d);
    n = 0;
    step();
    while (!rx_ack && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ack"}, rx_ack, 1);
    rx_valid = 1'b0;
    step();
    check({tag, "_ack_drop"}, rx_ack, 0);
  endtask

  // Scoreboard pop + compare against the head, then a take pulse.
  task automatic take_check(input string tag);
    logic [W-1:0] e;
    check({tag, "_valid"}, rc_valid, 1);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rc_data, e);
    end
    rc_taken = 1'b1;
    step();
    rc_taken = 1'b0;
  endtask

  initial begin
    int sent;
    int cyc;
    logic [W-1:0] e;

    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = pkt(32'h77);
    rc_taken = 1'b0;

    // Reset held 3 cycles with Valid high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ack", rx_ack, 0);
      check("rst_cnt", fifo_count, 0);
      check("rst_rcv", rc_valid, 0);
      check("rst_rcd", rc_data, 0);
      check("rst_perr", parity_err, 0);
      check("rst_state", fsm_state, 0);
    end
    rst = 1'b0;
    exp_q.push_back(pkt(32'h77));
    step();
    check("post_rst_ack", rx_ack, 0);
    check("post_rst_cnt", fifo_count, 0);
    check("post_rst_state", fsm_state, 1);
    step();
    check("post_rst_ack1", rx_ack, 1);
    check("post_rst_cnt1", fifo_count, 1);
    rx_valid = 1'b0;
    step();
    take_check("post_rst_take");
    check("post_rst_cnt0", fifo_count, 0);

    // Single packet with a long hold
    rx_data  = pkt(32'h1234);
    rx_valid = 1'b1;
    exp_q.push_back(pkt(32'h1234));
    step();
    check("single_ack", rx_ack, 1);
    check("single_rcv", rc_valid, 1);
    check("single_rcd", rc_data, pkt(32'h1234));
    check("single_perr", parity_err, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("single_hold_ack", rx_ack, 1);
      check("single_hold_cnt", fifo_count, 1);
    end
    rx_valid = 1'b0;
    step();
    check("single_ack_drop", rx_ack, 0);
    take_check("single_take");
    check("single_cnt0", fifo_count, 0);

    // Fill to DEPTH, then back-pressure on packet 5
    for (int i = 1; i <= 4; i++) send_pkt(pkt(i), "fill");
    check("fill_cnt4", fifo_count, 4);
    rx_data  = pkt(5);
    rx_valid = 1'b1;
    exp_q.push_back(pkt(5));
    step();
    check("bp_ack0", rx_ack, 0);
    check("bp_cnt4", fifo_count, 4);
    step();
    check("bp_ack0b", rx_ack, 0);
    take_check("bp_take");
    check("bp_take_ack0", rx_ack, 0);
    check("bp_take_cnt3", fifo_count, 3);
    step();
    check("bp_late_ack", rx_ack, 1);
    check("bp_late_cnt4", fifo_count, 4);
    rx_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) take_check("drain");
    check("drain_cnt0", fifo_count, 0);
    check("drain_sb_empty", exp_q.size(), 0);

    // Streaming 10 packets with a take whenever data is valid
    sent = 0;
    cyc  = 0;
    while ((sent < 10 || exp_q.size() != 0 || rx_valid) && cyc < 300) begin
      rc_taken = 1'b0;
      if (rc_valid) begin
        check("wrap_sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wrap_data", rc_data, e);
        end
        rc_taken = 1'b1;
      end
      check("wrap_cnt_le2", fifo_count <= 2, 1);
      if (rx_valid && rx_ack) begin
        rx_valid = 1'b0;
      end else if (!rx_valid && !rx_ack && sent < 10) begin
        rx_data  = pkt(32'h10 + sent);
        rx_valid = 1'b1;
        exp_q.push_back(pkt(32'h10 + sent));
        sent++;
      end
      step();
      cyc++;
    end
    rc_taken = 1'b0;
    check("wrap_in_budget", cyc < 300, 1);
    check("wrap_sent", sent, 10);
    step();
    check("wrap_cnt0", fifo_count, 0);

    // Take while empty is ignored
    rc_taken = 1'b1;
    step();
    rc_taken = 1'b0;
    check("empty_take_cnt", fifo_count, 0);
    check("empty_take_rcv", rc_valid, 0);
    check("empty_take_rcd", rc_data, 0);

    // Reset while in ACK with two entries buffered
    send_pkt(pkt(32'h2A), "rstack");
    rx_data  = pkt(32'h2B);
    rx_valid = 1'b1;
    step();
    check("rstack_ack", rx_ack, 1);
    check("rstack_cnt2", fifo_count, 2);
    rst = 1'b1;
    step();
    check("rstack_ack0", rx_ack, 0);
    check("rstack_cnt0", fifo_count, 0);
    check("rstack_rcv0", rc_valid, 0);
    check("rstack_state", fsm_state, 0);
    exp_q.delete();
    rst      = 1'b0;
    rx_valid = 1'b0;
    step();
    step();
    check("rstack_idle", fsm_state, 1);

`ifdef RXHS_PARITY_CHECK_EN
    // Bad parity: acknowledged, dropped, one-cycle error pulse
    rx_data  = 55'h0000_0000_0001;
    rx_valid = 1'b1;
    step();
    check("par_bad_ack", rx_ack, 1);
    check("par_bad_perr", parity_err, 1);
    check("par_bad_cnt", fifo_count, 0);
    step();
    check("par_bad_perr_clr", parity_err, 0);
    rx_valid = 1'b0;
    step();
    // Good parity: written normally
    rx_data  = 55'h40_0000_0000_0001;
    rx_valid = 1'b1;
    exp_q.push_back(55'h40_0000_0000_0001);
    step();
    check("par_good_ack", rx_ack, 1);
    check("par_good_perr", parity_err, 0);
    check("par_good_cnt", fifo_count, 1);
    rx_valid = 1'b0;
    step();
    take_check("par_good_take");
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
